// File: rtl/idli_sqi_fetch.sv
// Instruction fetch unit: streams 16b words from the paired SQI memories
// (low/high nibble parts) using sequential READ and hands them to the decoder.
module idli_sqi_fetch #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned DUMMY_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_redirect_vld,
  input  logic [15:0]     i_redirect_pc,
  output logic            o_instr_vld,
  output logic [15:0]     o_instr,
  output logic [15:0]     o_instr_pc,
  input  logic            i_instr_rdy,
  output logic            o_sqi_cs_n,
  output logic            o_sqi_sck_en,
  output logic            o_sqi_oe,
  output logic [1:0][3:0] o_sqi_data,
  input  logic [1:0][3:0] i_sqi_data
);

  localparam int SQI_MEM_LO = 0;
  localparam int SQI_MEM_HI = 1;
  localparam logic [3:0] CMD_LAST   = 4'd1;
  localparam logic [3:0] ADDR_LAST  = 4'd5;
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic [15:0] pc_q, pc_d;
  logic        byte_sel_q, byte_sel_d;
  logic [7:0]  lo_byte_q, lo_byte_d;
  logic        instr_vld_q, instr_vld_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;

  logic [23:0] addr_sh;
  logic [3:0]  data_nib;
  logic [7:0]  rx_byte;
  logic        consume;
  logic        sample_en;

  // Shift the byte address so the nibble for the current phase sits on top.
  assign addr_sh = {7'b0, pc_q, 1'b0} << {phase_q, 2'b00};
  assign rx_byte = {i_sqi_data[SQI_MEM_HI], i_sqi_data[SQI_MEM_LO]};
  assign consume = instr_vld_q & i_instr_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= 4'd0;
      pc_q        <= RESET_PC;
      byte_sel_q  <= 1'b0;
      lo_byte_q   <= 8'd0;
      instr_vld_q <= 1'b0;
      instr_q     <= 16'd0;
      instr_pc_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pc_q        <= pc_d;
      byte_sel_q  <= byte_sel_d;
      lo_byte_q   <= lo_byte_d;
      instr_vld_q <= instr_vld_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    pc_d         = pc_q;
    byte_sel_d   = byte_sel_q;
    lo_byte_d    = lo_byte_q;
    instr_vld_d  = instr_vld_q;
    instr_d      = instr_q;
    instr_pc_d   = instr_pc_q;
    o_sqi_cs_n   = 1'b1;
    o_sqi_sck_en = 1'b0;
    o_sqi_oe     = 1'b0;
    data_nib     = 4'h0;
    sample_en    = 1'b0;

    if (consume) begin
      instr_vld_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        state_d = ST_CMD;
        phase_d = 4'd0;
      end
      ST_CMD: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = 1'b1;
        data_nib     = phase_q[0] ? 4'h3 : 4'h0;
        if (phase_q == CMD_LAST) begin
          state_d = ST_ADDR;
          phase_d = 4'd0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_ADDR: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        o_sqi_oe     = 1'b1;
        data_nib     = addr_sh[23:20];
        if (phase_q == ADDR_LAST) begin
          state_d = ST_DUMMY;
          phase_d = 4'd0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_DUMMY: begin
        o_sqi_cs_n   = 1'b0;
        o_sqi_sck_en = 1'b1;
        if (phase_q == DUMMY_LAST) begin
          state_d = ST_DATA;
          phase_d = 4'd0;
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      ST_DATA: begin
        o_sqi_cs_n = 1'b0;
        // Stall the clock only on the byte that would complete a word with nowhere to go.
        sample_en    = ~(byte_sel_q & instr_vld_q & ~i_instr_rdy);
        o_sqi_sck_en = sample_en;
        if (sample_en) begin
          if (!byte_sel_q) begin
            lo_byte_d  = rx_byte;
            byte_sel_d = 1'b1;
          end else begin
            instr_d     = {rx_byte, lo_byte_q};
            instr_pc_d  = pc_q;
            instr_vld_d = 1'b1;
            pc_d        = pc_q + 16'd1;
            byte_sel_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = 4'd0;
      end
    endcase

    if (i_redirect_vld) begin
      state_d     = ST_IDLE;
      phase_d     = 4'd0;
      pc_d        = i_redirect_pc;
      instr_vld_d = 1'b0;
      byte_sel_d  = 1'b0;
      lo_byte_d   = 8'd0;
    end

    // Deselect the memories in the very cycle reset is raised.
    if (i_rst) begin
      o_sqi_cs_n   = 1'b1;
      o_sqi_sck_en = 1'b0;
      o_sqi_oe     = 1'b0;
      data_nib     = 4'h0;
    end
  end

  assign o_sqi_data  = {data_nib, data_nib};
  assign o_instr_vld = instr_vld_q;
  assign o_instr     = instr_q;
  assign o_instr_pc  = instr_pc_q;

endmodule

// File: tb/tb_idli_sqi_fetch.sv
// Bench for idli_sqi_fetch: behavioural SQI memory pair plus a scoreboard of
// expected {pc, instr} words checked at every decoder handshake.
module tb_idli_sqi_fetch;

  localparam int          DUMMY  = 2;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            redirect_vld;
  logic [15:0]     redirect_pc;
  logic            instr_vld;
  logic [15:0]     instr;
  logic [15:0]     instr_pc;
  logic            instr_rdy;
  logic            cs_n;
  logic            sck_en;
  logic            oe;
  logic [1:0][3:0] sqi_out;
  logic [1:0][3:0] sqi_in;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [23:0] exp_addr;

  always #5 clk = ~clk;

  idli_sqi_fetch #(
    .RESET_PC    (RST_PC),
    .DUMMY_CYCLES(DUMMY)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_redirect_vld(redirect_vld),
    .i_redirect_pc (redirect_pc),
    .o_instr_vld   (instr_vld),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_rdy   (instr_rdy),
    .o_sqi_cs_n    (cs_n),
    .o_sqi_sck_en  (sck_en),
    .o_sqi_oe      (oe),
    .o_sqi_data    (sqi_out),
    .i_sqi_data    (sqi_in)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [16:0] a);
    if (a == 17'd0) return 8'h14;
    if (a == 17'd1) return 8'hA2;
    return (a[7:0] * 8'd29) ^ {a[16:13], a[11:8]} ^ 8'h5A;
  endfunction

  function automatic logic [15:0] word_at(input logic [15:0] pc);
    logic [16:0] b;
    b = {pc, 1'b0};
    return {mem_byte(b + 17'd1), mem_byte(b)};
  endfunction

  task automatic push_stream(input logic [15:0] pc, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] p;
      p = pc + 16'(i);
      exp_q.push_back({p, word_at(p)});
    end
  endtask

  // Behavioural memory pair: snapshots the bus mid-cycle, advances on the clock edge.
  int          m_cnt = 0;
  logic [23:0] m_addr = '0;
  logic [7:0]  m_cmd = '0;
  logic [16:0] m_ptr = '0;
  logic        s_cs_n = 1'b1;
  logic        s_sck = 1'b0;
  logic        s_oe = 1'b0;
  logic [1:0][3:0] s_data = '0;
  logic [7:0]  m_byte;

  always @(negedge clk) begin
    #2;
    s_cs_n <= cs_n;
    s_sck  <= sck_en;
    s_oe   <= oe;
    s_data <= sqi_out;
  end

  always @(posedge clk) begin
    logic [23:0] full;
    if (s_cs_n) begin
      m_cnt <= 0;
    end else if (s_sck) begin
      if (m_cnt < 8 + DUMMY) m_cnt <= m_cnt + 1;
      if (m_cnt < 8) begin
        chk("sqi_oe_cmdaddr", 32'(s_oe), 32'd1);
        chk("sqi_lanes_equal", 32'(s_data[1]), 32'(s_data[0]));
      end else if (m_cnt < 8 + DUMMY) begin
        chk("sqi_oe_dummy", 32'(s_oe), 32'd0);
      end
      if (m_cnt < 2) m_cmd <= {m_cmd[3:0], s_data[0]};
      if (m_cnt == 1) chk("sqi_cmd", 32'({m_cmd[3:0], s_data[0]}), 32'h03);
      if (m_cnt >= 2 && m_cnt < 8) m_addr <= {m_addr[19:0], s_data[0]};
      if (m_cnt == 7) begin
        full = {m_addr[19:0], s_data[0]};
        chk("sqi_addr", 32'(full), 32'(exp_addr));
        m_ptr <= full[16:0];
      end
      if (m_cnt >= 8 + DUMMY) m_ptr <= m_ptr + 17'd1;
    end
  end

  assign m_byte = mem_byte(m_ptr);
  assign sqi_in = (m_cnt >= 8 + DUMMY) ? {m_byte[7:4], m_byte[3:0]} : '0;

  // One clock: score a handshake happening this cycle, then advance to the next negedge.
  task automatic step();
    logic [31:0] e;
    #1;
    if (!rst && instr_vld && instr_rdy) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        $display("txn pc=%h instr=%h", instr_pc, instr);
        chk("instr_pc", 32'(instr_pc), 32'(e[31:16]));
        chk("instr", 32'(instr), 32'(e[15:0]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_vld(input int max);
    int n;
    n = 0;
    while (!instr_vld && n < max) begin
      step();
      n++;
    end
    chk("vld_timeout", 32'(instr_vld), 32'd1);
  endtask

  task automatic redirect(input logic [15:0] pc);
    redirect_vld = 1'b1;
    redirect_pc  = pc;
    step();
    redirect_vld = 1'b0;
    exp_q.delete();
    push_stream(pc, 16);
    exp_addr = {7'b0, pc, 1'b0};
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    redirect_vld = 1'b0;
    redirect_pc  = 16'h0;
    instr_rdy    = 1'b1;
    exp_addr     = {7'b0, RST_PC, 1'b0};
    repeat (3) @(negedge clk);

    chk("rst_vld", 32'(instr_vld), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_sck_en", 32'(sck_en), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_data", 32'(sqi_out), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);

    // Fill latency and command/address sequencing after reset release.
    push_stream(RST_PC, 64);
    rst = 1'b0;
    for (int c = 0; c <= 13; c++) begin
      if (c == 0) chk("idle_cs_n", 32'(cs_n), 32'd1);
      if (c >= 1 && c <= 10) chk("stream_cs_n", 32'(cs_n), 32'd0);
      if (c == 1) chk("cmd_nib0", 32'(sqi_out[0]), 32'h0);
      if (c == 2) chk("cmd_nib1", 32'(sqi_out[0]), 32'h3);
      if (c >= 3 && c <= 8) chk("addr_nib", 32'(sqi_out[0]), 32'h0);
      if (c == 9 || c == 10) chk("dummy_oe", 32'(oe), 32'd0);
      if (c < 13) chk("fill_vld", 32'(instr_vld), 32'd0);
      else        chk("first_vld", 32'(instr_vld), 32'd1);
      if (c < 13) step();
    end

    // Full-rate streaming: a word every second cycle.
    for (int c = 13; c <= 20; c++) begin
      chk("stream_cs_n", 32'(cs_n), 32'd0);
      chk("stream_vld", 32'(instr_vld), 32'(c % 2));
      step();
    end

    // Backpressure: hold the word for 5 cycles, clock must stop on the completing byte.
    instr_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_vld", 32'(instr_vld), 32'd1);
      chk("stall_pc", 32'(instr_pc), 32'(exp_q[0][31:16]));
      chk("stall_instr", 32'(instr), 32'(exp_q[0][15:0]));
      chk("stall_cs_n", 32'(cs_n), 32'd0);
      if (i >= 1) chk("stall_sck_en", 32'(sck_en), 32'd0);
      step();
    end
    instr_rdy = 1'b1;
    step();
    chk("resume_vld", 32'(instr_vld), 32'd1);
    chk("resume_pc", 32'(instr_pc), 32'(exp_q[0][31:16]));
    repeat (6) step();

    // Redirect in the middle of the data phase.
    redirect(16'h1234);
    chk("redir_vld", 32'(instr_vld), 32'd0);
    chk("redir_cs_n", 32'(cs_n), 32'd1);
    wait_vld(40);
    chk("redir_first_pc", 32'(instr_pc), 32'h1234);
    repeat (8) step();

    // Back-to-back redirects: the later one must win.
    redirect(16'h0100);
    redirect(16'h0200);
    wait_vld(40);
    chk("b2b_first_pc", 32'(instr_pc), 32'h0200);
    repeat (6) step();

    // PC wrap: the stream continues through 0xFFFF -> 0x0000 without reissuing.
    redirect(16'hFFFE);
    wait_vld(40);
    for (int i = 0; i < 8; i++) begin
      chk("wrap_cs_n", 32'(cs_n), 32'd0);
      step();
    end

    // Reset raised during the address phase.
    redirect(16'h0050);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("rst_now_cs_n", 32'(cs_n), 32'd1);
    chk("rst_now_sck_en", 32'(sck_en), 32'd0);
    step();
    chk("rst_mid_cs_n", 32'(cs_n), 32'd1);
    chk("rst_mid_oe", 32'(oe), 32'd0);
    chk("rst_mid_sck_en", 32'(sck_en), 32'd0);
    chk("rst_mid_vld", 32'(instr_vld), 32'd0);
    exp_q.delete();
    push_stream(RST_PC, 16);
    exp_addr = {7'b0, RST_PC, 1'b0};
    step();
    rst = 1'b0;
    wait_vld(40);
    chk("rst_restart_pc", 32'(instr_pc), 32'(RST_PC));
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
